// File: rtl/top_tema.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : top_tema
// Brief    : Registered 3-bit ALU with X/Y operand multiplexers and carry flag.
//            Define TOP_TEMA_EXT_OPS_EN to enable the SHL/SHR opcodes (6/7).
// Revision : 1.0 - initial release
// ============================================================================
module top_tema (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] a,
    input  logic [2:0] b,
    input  logic [2:0] c,
    input  logic [2:0] d,
    input  logic [2:0] e,
    input  logic [2:0] opcode,
    input  logic       sel_1,
    input  logic [1:0] sel_2,
    output logic [2:0] out,
    output logic       carry_out
);

    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_AND = 3'd2;
    localparam logic [2:0] c_OP_OR  = 3'd3;
    localparam logic [2:0] c_OP_XOR = 3'd4;
    localparam logic [2:0] c_OP_NOT = 3'd5;
`ifdef TOP_TEMA_EXT_OPS_EN
    localparam logic [2:0] c_OP_SHL = 3'd6;
    localparam logic [2:0] c_OP_SHR = 3'd7;
`endif

    logic [2:0] w_x;
    logic [2:0] w_y;
    logic [2:0] w_res;
    logic       w_flag;
    logic [3:0] w_sum;
    logic [3:0] w_diff;
    logic [2:0] r_out;
    logic       r_carry;

    assign w_x = sel_1 ? c : a;

    always_comb begin
        w_y = b;
        case (sel_2)
            2'd0:    w_y = b;
            2'd1:    w_y = d;
            2'd2:    w_y = e;
            default: w_y = c;
        endcase
    end

    // Bit 3 of the 4-bit difference is the borrow for unsigned X < Y.
    assign w_sum  = {1'b0, w_x} + {1'b0, w_y};
    assign w_diff = {1'b0, w_x} - {1'b0, w_y};

    always_comb begin
        w_res  = 3'd0;
        w_flag = 1'b0;
        case (opcode)
            c_OP_ADD: begin
                w_res  = w_sum[2:0];
                w_flag = w_sum[3];
            end
            c_OP_SUB: begin
                w_res  = w_diff[2:0];
                w_flag = w_diff[3];
            end
            c_OP_AND: w_res = w_x & w_y;
            c_OP_OR:  w_res = w_x | w_y;
            c_OP_XOR: w_res = w_x ^ w_y;
            c_OP_NOT: w_res = ~w_x;
`ifdef TOP_TEMA_EXT_OPS_EN
            c_OP_SHL: begin
                w_res  = {w_x[1:0], 1'b0};
                w_flag = w_x[2];
            end
            c_OP_SHR: begin
                w_res  = {1'b0, w_x[2:1]};
                w_flag = w_x[0];
            end
`else
            // Opcodes 6/7 fall through to a zero result with no shifter built.
`endif
            default: begin
                w_res  = 3'd0;
                w_flag = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= 3'd0;
            r_carry <= 1'b0;
        end else begin
            r_out   <= w_res;
            r_carry <= w_flag;
        end
    end

    assign out       = r_out;
    assign carry_out = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_top_tema.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_top_tema
// Brief    : Self-checking bench for top_tema: directed literals plus random
//            stimulus compared each cycle against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_top_tema;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] a, b, c, d, e, opcode;
    logic       sel_1;
    logic [1:0] sel_2;
    logic [2:0] out;
    logic       carry_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] m_out;
    logic       m_c;

    top_tema dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .e         (e),
        .opcode    (opcode),
        .sel_1     (sel_1),
        .sel_2     (sel_2),
        .out       (out),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    // Reference computed with plain integer arithmetic; returns {flag, result}.
    function automatic logic [3:0] alu_model(input int op, input int s1, input int s2,
                                             input int va, input int vb, input int vc,
                                             input int vd, input int ve);
        int x, y, r, f;
        logic [3:0] ret;
        x = (s1 != 0) ? vc : va;
        case (s2)
            0:       y = vb;
            1:       y = vd;
            2:       y = ve;
            default: y = vc;
        endcase
        r = 0;
        f = 0;
        case (op)
            0: begin r = (x + y) % 8; f = (x + y > 7) ? 1 : 0; end
            1: begin r = (x - y + 8) % 8; f = (x < y) ? 1 : 0; end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: r = 7 - x;
`ifdef TOP_TEMA_EXT_OPS_EN
            6: begin r = (x * 2) % 8; f = x / 4; end
            7: begin r = x / 2; f = x % 2; end
`endif
            default: begin r = 0; f = 0; end
        endcase
        ret = {f[0], r[2:0]};
        return ret;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            {m_c, m_out} <= 4'd0;
        else
            {m_c, m_out} <= alu_model(int'(opcode), int'(sel_1), int'(sel_2),
                                      int'(a), int'(b), int'(c), int'(d), int'(e));
    end

    task automatic chk(input string name, input logic [2:0] got_o, input logic got_c,
                       input logic [2:0] exp_o, input logic exp_c);
        n_tests++;
        if (got_o !== exp_o || got_c !== exp_c) begin
            n_fail++;
            $display("FAIL %s: out=%0d carry=%0d, expected out=%0d carry=%0d",
                     name, got_o, got_c, exp_o, exp_c);
        end
    endtask

    // One clock, then the per-cycle compare against the model.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("model", out, carry_out, m_out, m_c);
    endtask

    task automatic dir(input string name, input logic [2:0] eo, input logic ec);
        tick();
        chk(name, out, carry_out, eo, ec);
        chk({name, "_mdl"}, m_out, m_c, eo, ec);
    endtask

    task automatic set_default();
        a = 3'd2; b = 3'd3; c = 3'd1; d = 3'd4; e = 3'd6;
        sel_1 = 1'b0; sel_2 = 2'd0;
    endtask

    logic [2:0] op_exp_o [6] = '{3'd5, 3'd7, 3'd2, 3'd3, 3'd1, 3'd5};
    logic       op_exp_c [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        rst_n  = 1'b0;
        opcode = 3'd0;
        set_default();
        #12;
        chk("reset_init", out, carry_out, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Opcodes 0..5 back to back: each edge shows the previous cycle's op.
        for (int op = 0; op < 6; op++) begin
            opcode = 3'(op);
            dir($sformatf("op%0d", op), op_exp_o[op], op_exp_c[op]);
        end

        // Y mux
        opcode = 3'd0;
        sel_2 = 2'd1; dir("ymux1", 3'd6, 1'b0);
        sel_2 = 2'd2; dir("ymux2", 3'd0, 1'b1);
        sel_2 = 2'd3; dir("ymux3", 3'd3, 1'b0);

        // X mux
        sel_1 = 1'b1; sel_2 = 2'd2; dir("xmux1", 3'd7, 1'b0);
        a = 3'd7; b = 3'd7; sel_1 = 1'b0; sel_2 = 2'd0; dir("add_carry", 3'd6, 1'b1);

        // Optional shift opcodes
        set_default();
        a = 3'd6;
`ifdef TOP_TEMA_EXT_OPS_EN
        opcode = 3'd6; dir("shl", 3'd4, 1'b1);
        opcode = 3'd7; dir("shr", 3'd3, 1'b0);
`else
        opcode = 3'd6; dir("op6_off", 3'd0, 1'b0);
        opcode = 3'd7; dir("op7_off", 3'd0, 1'b0);
`endif

        // Asynchronous reset asserted mid high phase
        set_default();
        opcode = 3'd1;
        dir("pre_reset", 3'd7, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("reset_async", out, carry_out, 3'd0, 1'b0);
        @(negedge clk);
        chk("reset_hold1", out, carry_out, 3'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("reset_hold2", out, carry_out, 3'd0, 1'b0);
        rst_n = 1'b1;
        #1 chk("reset_release", out, carry_out, 3'd0, 1'b0);
        dir("post_reset", 3'd7, 1'b1);

        // Random stimulus with occasional short reset pulses
        for (int i = 0; i < 400; i++) begin
            a = 3'($urandom); b = 3'($urandom); c = 3'($urandom);
            d = 3'($urandom); e = 3'($urandom);
            opcode = 3'($urandom);
            sel_1  = 1'($urandom);
            sel_2  = 2'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                #1 rst_n = 1'b0;
                #1 chk("rand_reset", out, carry_out, 3'd0, 1'b0);
                #1 rst_n = 1'b1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
